// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes and the
// write/read FSM state encodings used by the register slaves.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    WR_COLLECT = 1'b0,
    WR_RESP    = 1'b1
  } wr_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_t;

endpackage

// File: rtl/axi_lite_wstrb_merge.sv
// Byte-strobe merge: old_word with the bytes of new_word
// selected by strb (one strobe bit per byte) -> merged_word.
module axi_lite_wstrb_merge
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_word,
  input  logic [DATA_WIDTH-1:0]   new_word,
  input  logic [DATA_WIDTH/8-1:0] strb,
  output logic [DATA_WIDTH-1:0]   merged_word
);

  localparam int STRB_W = DATA_WIDTH / 8;

  always_comb begin
    merged_word = old_word;
    for (int k = 0; k < STRB_W; k++) begin
      if (strb[k]) begin
        merged_word[8*k +: 8] = new_word[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI-Lite slave over a bank of byte-writable registers.
// Ports: AXI-Lite S_* channels, reg_out (flat bank), wr_pulse.
module axi_lite_reg_slave
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 16,
  parameter int WINDOW_BITS = 12,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          S_awaddr,
  input  logic                           S_awvalid,
  output logic                           S_awready,
  input  logic [DATA_WIDTH-1:0]          S_wdata,
  input  logic [DATA_WIDTH/8-1:0]        S_wstrb,
  input  logic                           S_wvalid,
  output logic                           S_wready,
  output logic [1:0]                     S_bresp,
  output logic                           S_bvalid,
  input  logic                           S_bready,
  input  logic [ADDR_WIDTH-1:0]          S_araddr,
  input  logic                           S_arvalid,
  output logic                           S_arready,
  output logic [DATA_WIDTH-1:0]          S_rdata,
  output logic [1:0]                     S_rresp,
  output logic                           S_rvalid,
  input  logic                           S_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = WINDOW_BITS - 2;
  localparam int SEL_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IDX_W-1:0] IDX_LIM = IDX_W'(NUM_REGS);

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic                  aw_held, w_held;
  logic [IDX_W-1:0]      aw_idx;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] merged;

  logic             aw_hs, w_hs, ar_hs, commit;
  logic             w_in_range, ar_in_range;
  logic [IDX_W-1:0] ar_idx;
  logic [SEL_W-1:0] w_sel, ar_sel;

  logic unused_addr;
  assign unused_addr = ^{S_awaddr[ADDR_WIDTH-1:WINDOW_BITS],
                         S_awaddr[1:0],
                         S_araddr[ADDR_WIDTH-1:WINDOW_BITS],
                         S_araddr[1:0]};

  // Readies come from state and held flags only.
  assign S_awready = (wr_state == WR_COLLECT) && !aw_held;
  assign S_wready  = (wr_state == WR_COLLECT) && !w_held;
  assign S_arready = (rd_state == RD_IDLE);
  assign S_bvalid  = (wr_state == WR_RESP);
  assign S_rvalid  = (rd_state == RD_RESP);

  assign aw_hs  = S_awvalid && S_awready;
  assign w_hs   = S_wvalid && S_wready;
  assign ar_hs  = S_arvalid && S_arready;
  assign commit = (wr_state == WR_COLLECT) && aw_held && w_held;

  assign ar_idx      = S_araddr[WINDOW_BITS-1:2];
  assign w_in_range  = aw_idx < IDX_LIM;
  assign ar_in_range = ar_idx < IDX_LIM;
  assign w_sel       = aw_idx[SEL_W-1:0];
  assign ar_sel      = ar_idx[SEL_W-1:0];

  axi_lite_wstrb_merge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_merge (
    .old_word    (regs[w_sel]),
    .new_word    (w_data),
    .strb        (w_strb),
    .merged_word (merged)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_state <= WR_COLLECT;
      rd_state <= RD_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  always_comb begin
    wr_next = wr_state;
    unique case (wr_state)
      WR_COLLECT: if (commit)   wr_next = WR_RESP;
      WR_RESP:    if (S_bready) wr_next = WR_COLLECT;
    endcase
  end

  always_comb begin
    rd_next = rd_state;
    unique case (rd_state)
      RD_IDLE: if (ar_hs)    rd_next = RD_RESP;
      RD_RESP: if (S_rready) rd_next = RD_IDLE;
    endcase
  end

  // AW and W are collected independently, in any order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_idx  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_idx  <= S_awaddr[WINDOW_BITS-1:2];
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= S_wdata;
        w_strb <= S_wstrb;
      end
    end
  end

  // Pulse fires on any in-range commit, even with wstrb = 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RESET_VAL;
      end
      wr_pulse <= '0;
      S_bresp  <= RESP_OKAY;
    end else begin
      wr_pulse <= '0;
      if (commit) begin
        if (w_in_range) begin
          regs[w_sel]     <= merged;
          wr_pulse[w_sel] <= 1'b1;
          S_bresp         <= RESP_OKAY;
        end else begin
          S_bresp <= RESP_SLVERR;
        end
      end
    end
  end

  // Read samples the pre-edge register value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      S_rdata <= '0;
      S_rresp <= RESP_OKAY;
    end else if (ar_hs) begin
      if (ar_in_range) begin
        S_rdata <= regs[ar_sel];
        S_rresp <= RESP_OKAY;
      end else begin
        S_rdata <= '0;
        S_rresp <= RESP_SLVERR;
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
    assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Self-checking bench for axi_lite_reg_slave: directed
// stimulus with a B/R response scoreboard and a register model.
module tb_axi_lite_reg_slave;

  logic         clk;
  logic         reset;
  logic [31:0]  S_awaddr;
  logic         S_awvalid;
  logic         S_awready;
  logic [31:0]  S_wdata;
  logic [3:0]   S_wstrb;
  logic         S_wvalid;
  logic         S_wready;
  logic [1:0]   S_bresp;
  logic         S_bvalid;
  logic         S_bready;
  logic [31:0]  S_araddr;
  logic         S_arvalid;
  logic         S_arready;
  logic [31:0]  S_rdata;
  logic [1:0]   S_rresp;
  logic         S_rvalid;
  logic         S_rready;
  logic [511:0] reg_out;
  logic [15:0]  wr_pulse;

  int checks = 0;
  int errors = 0;

  logic [1:0]  exp_b [$];
  logic [33:0] exp_r [$];
  logic [31:0] mdl [16];

  axi_lite_reg_slave dut (
    .clk       (clk),
    .reset     (reset),
    .S_awaddr  (S_awaddr),
    .S_awvalid (S_awvalid),
    .S_awready (S_awready),
    .S_wdata   (S_wdata),
    .S_wstrb   (S_wstrb),
    .S_wvalid  (S_wvalid),
    .S_wready  (S_wready),
    .S_bresp   (S_bresp),
    .S_bvalid  (S_bvalid),
    .S_bready  (S_bready),
    .S_araddr  (S_araddr),
    .S_arvalid (S_arvalid),
    .S_arready (S_arready),
    .S_rdata   (S_rdata),
    .S_rresp   (S_rresp),
    .S_rvalid  (S_rvalid),
    .S_rready  (S_rready),
    .reg_out   (reg_out),
    .wr_pulse  (wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [511:0] got,
                     input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] mdl_flat();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = mdl[i];
    return v;
  endfunction

  function automatic void exp_write(input logic [31:0] a,
                                    input logic [31:0] d,
                                    input logic [3:0]  s);
    int idx = int'(a[11:2]);
    if (idx < 16) begin
      for (int k = 0; k < 4; k++)
        if (s[k]) mdl[idx][8*k +: 8] = d[8*k +: 8];
      exp_b.push_back(2'b00);
    end else begin
      exp_b.push_back(2'b10);
    end
  endfunction

  function automatic void exp_read(input logic [31:0] a);
    int idx = int'(a[11:2]);
    if (idx < 16) exp_r.push_back({2'b00, mdl[idx]});
    else          exp_r.push_back({2'b10, 32'h0});
  endfunction

  // Handshakes complete at the posedge; compare at the negedge before.
  always @(negedge clk) begin
    if (reset && S_bvalid && S_bready) begin
      if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
      else chk("bresp", S_bresp, exp_b.pop_front());
    end
    if (reset && S_rvalid && S_rready) begin
      if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
      else chk("rresp_rdata", {S_rresp, S_rdata}, exp_r.pop_front());
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit do_aw, input bit do_w,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [3:0]  s);
    logic aa, ww;
    S_awaddr  = a;
    S_wdata   = d;
    S_wstrb   = s;
    S_awvalid = do_aw;
    S_wvalid  = do_w;
    for (int n = 0; n < 50 && (S_awvalid || S_wvalid); n++) begin
      aa = S_awvalid && S_awready;
      ww = S_wvalid && S_wready;
      tick();
      if (aa) S_awvalid = 1'b0;
      if (ww) S_wvalid = 1'b0;
    end
    if (S_awvalid || S_wvalid) begin
      chk("aw_w_timeout", {S_awvalid, S_wvalid}, 0);
      S_awvalid = 1'b0;
      S_wvalid  = 1'b0;
    end
  endtask

  task automatic send_ar(input logic [31:0] a);
    logic hs;
    S_araddr  = a;
    S_arvalid = 1'b1;
    for (int n = 0; n < 50 && S_arvalid; n++) begin
      hs = S_arready;
      tick();
      if (hs) S_arvalid = 1'b0;
    end
    if (S_arvalid) begin
      chk("ar_timeout", 1, 0);
      S_arvalid = 1'b0;
    end
  endtask

  task automatic drain;
    int n = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 50) begin
      tick();
      n++;
    end
    chk("drain_left", exp_b.size() + exp_r.size(), 0);
    tick();
  endtask

  initial begin
    reset     = 1'b0;
    S_awaddr  = '0;
    S_awvalid = 1'b0;
    S_wdata   = '0;
    S_wstrb   = '0;
    S_wvalid  = 1'b0;
    S_bready  = 1'b1;
    S_araddr  = '0;
    S_arvalid = 1'b0;
    S_rready  = 1'b1;
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    chk("rst_bvalid", S_bvalid, 0);
    chk("rst_rvalid", S_rvalid, 0);
    chk("rst_ready", {S_awready, S_wready, S_arready}, 3'b111);
    chk("rst_resp", {S_bresp, S_rresp}, 0);
    chk("rst_rdata", S_rdata, 0);
    chk("rst_pulse", wr_pulse, 0);
    chk("rst_regs", reg_out, 0);

    // 1: AW+W same cycle, visible two cycles later
    exp_write(32'h004, 32'hDEADBEEF, 4'hF);
    send(1, 1, 32'h004, 32'hDEADBEEF, 4'hF);
    chk("t1_bvalid_n1", S_bvalid, 0);
    chk("t1_pulse_n1", wr_pulse, 0);
    tick();
    chk("t1_bvalid_n2", S_bvalid, 1);
    chk("t1_pulse_n2", wr_pulse, 16'h0002);
    chk("t1_reg1", reg_out[32 +: 32], 32'hDEADBEEF);
    tick();
    chk("t1_pulse_n3", wr_pulse, 0);
    chk("t1_bvalid_n3", S_bvalid, 0);
    drain();

    // 2: W leads AW by three cycles
    exp_write(32'h004, 32'h000000AA, 4'h1);
    send(0, 1, 32'h0, 32'h000000AA, 4'h1);
    for (int i = 0; i < 2; i++) begin
      chk("t2_wready_held", S_wready, 0);
      chk("t2_awready", S_awready, 1);
      tick();
    end
    send(1, 0, 32'h004, 32'h0, 4'h0);
    chk("t2_wready_commit", S_wready, 0);
    tick();
    chk("t2_bvalid", S_bvalid, 1);
    chk("t2_wready_resp", S_wready, 0);
    chk("t2_reg1", reg_out[32 +: 32], 32'hDEADBEAA);
    tick();
    chk("t2_wready_free", S_wready, 1);
    drain();

    // 3: read with R back-pressure, then out-of-range read
    S_rready = 1'b0;
    exp_read(32'h004);
    send_ar(32'h004);
    for (int i = 0; i < 4; i++) begin
      chk("t3_rvalid", S_rvalid, 1);
      chk("t3_rdata", S_rdata, 32'hDEADBEAA);
      chk("t3_arready", S_arready, 0);
      tick();
    end
    S_rready = 1'b1;
    drain();
    exp_read(32'h040);
    send_ar(32'h040);
    chk("t3_oor_rresp", S_rresp, 2'b10);
    drain();

    // 4: out-of-range write with B back-pressure
    S_bready = 1'b0;
    exp_write(32'h07C, 32'h00001234, 4'hF);
    send(1, 1, 32'h07C, 32'h00001234, 4'hF);
    tick();
    chk("t4_pulse", wr_pulse, 0);
    chk("t4_regs", reg_out, mdl_flat());
    for (int i = 0; i < 5; i++) begin
      chk("t4_bvalid", S_bvalid, 1);
      chk("t4_bresp", S_bresp, 2'b10);
      chk("t4_ready", {S_awready, S_wready}, 0);
      tick();
    end
    S_bready = 1'b1;
    drain();

    // 5: read and write of reg2 on the same edge
    exp_read(32'h008);
    exp_write(32'h008, 32'h00000055, 4'hF);
    send(1, 1, 32'h008, 32'h00000055, 4'hF);
    S_araddr  = 32'h008;
    S_arvalid = 1'b1;
    tick();
    S_arvalid = 1'b0;
    chk("t5_rdata_old", S_rdata, 32'h0);
    chk("t5_reg2", reg_out[64 +: 32], 32'h55);
    drain();
    exp_read(32'h008);
    send_ar(32'h008);
    drain();

    // 6: reset while both channels wait for a response
    S_bready = 1'b0;
    S_rready = 1'b0;
    send(1, 1, 32'h00C, 32'hCAFEF00D, 4'hF);
    send_ar(32'h004);
    tick();
    chk("t6_pre_valid", {S_bvalid, S_rvalid}, 2'b11);
    reset = 1'b0;
    #1;
    chk("t6_valid_drop", {S_bvalid, S_rvalid}, 0);
    chk("t6_regs", reg_out, 0);
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
    tick();
    reset    = 1'b1;
    S_bready = 1'b1;
    S_rready = 1'b1;
    tick();
    exp_write(32'h00C, 32'h12345678, 4'hF);
    send(1, 1, 32'h00C, 32'h12345678, 4'hF);
    drain();
    exp_read(32'h00C);
    send_ar(32'h00C);
    drain();
    exp_read(32'h004);
    send_ar(32'h004);
    drain();
    chk("t6_regs_after", reg_out, mdl_flat());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
